// File: rtl/bp_cac_lce_req_packetizer.sv
// Serialises one LCE request (header, optional cache block) into wormhole flits for the request mesh link.
// Optional feature macro: BP_CAC_PACKETIZER_STALL_CNT_EN adds a saturating stall-cycle counter port.
module bp_cac_lce_req_packetizer #(
    parameter int flit_width_p   = 64,
    parameter int cord_width_p   = 8,
    parameter int len_width_p    = 4,
    parameter int header_width_p = 48,
    parameter int data_width_p   = 512
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      msg_v_i,
    output logic                      msg_ready_o,
    input  logic [cord_width_p-1:0]   dst_cord_i,
    input  logic [header_width_p-1:0] msg_header_i,
    input  logic                      msg_has_data_i,
    input  logic [data_width_p-1:0]   msg_data_i,
    output logic [flit_width_p-1:0]   link_data_o,
    output logic                      link_v_o,
    input  logic                      link_ready_and_i
`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    localparam int hdr_bits   = cord_width_p + len_width_p + header_width_p;
    localparam int full_bits  = hdr_bits + data_width_p;
    localparam int hdr_flits  = (hdr_bits + flit_width_p - 1) / flit_width_p;
    localparam int full_flits = (full_bits + flit_width_p - 1) / flit_width_p;
    localparam int img_bits   = full_flits * flit_width_p;

    if (full_flits - 1 > (2 ** len_width_p) - 1) begin : g_len_check
        $error("wormhole len field too narrow for a full data packet");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                   state_reg, state_next;
    logic [img_bits-1:0]      shift_reg, shift_next, shifted, image;
    logic [full_bits-1:0]     raw_image;
    logic [len_width_p-1:0]   cnt_reg, cnt_next, pkt_len;
    logic                     transfer, last, accept;

    assign pkt_len   = msg_has_data_i ? len_width_p'(full_flits - 1) : len_width_p'(hdr_flits - 1);
    assign raw_image = {(msg_has_data_i ? msg_data_i : {data_width_p{1'b0}}),
                        msg_header_i, pkt_len, dst_cord_i};
    assign image     = img_bits'(raw_image);

    // Drop the flit just sent; zeros fill from the top so an idle link shows zero data.
    genvar gi;
    for (gi = 0; gi < full_flits; gi++) begin : g_shift
        if (gi < full_flits - 1) begin : g_mid
            assign shifted[gi*flit_width_p +: flit_width_p] = shift_reg[(gi+1)*flit_width_p +: flit_width_p];
        end else begin : g_top
            assign shifted[gi*flit_width_p +: flit_width_p] = '0;
        end
    end

    assign transfer    = (state_reg == SEND) && link_ready_and_i;
    assign last        = transfer && (cnt_reg == '0);
    assign msg_ready_o = (state_reg == IDLE) || last;
    assign accept      = msg_v_i && msg_ready_o;
    assign link_v_o    = (state_reg == SEND);
    assign link_data_o = shift_reg[flit_width_p-1:0];

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        if (accept) begin
            // Also covers loading the next packet on the final-flit cycle.
            shift_next = image;
            cnt_next   = pkt_len;
            state_next = SEND;
        end else if (transfer) begin
            shift_next = shifted;
            if (last) begin
                state_next = IDLE;
            end else begin
                cnt_next = cnt_reg - len_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_reg <= '0;
        end else if (link_v_o && !link_ready_and_i && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

`ifndef SYNTHESIS
    // Upstream must hold a pending message steady until it is taken.
    a_msg_hold : assert property (@(posedge clk_i) disable iff (reset_i)
        (msg_v_i && !msg_ready_o) |=> ($stable(dst_cord_i) && $stable(msg_header_i)
                                       && $stable(msg_has_data_i) && $stable(msg_data_i)));
`endif

endmodule

// File: tb/tb_bp_cac_lce_req_packetizer.sv
// Self-checking bench for bp_cac_lce_req_packetizer: directed cases plus 1000 random messages
// checked every cycle against a flit-queue model built from the packet-image rules.
module tb_bp_cac_lce_req_packetizer;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         msg_v_i = 1'b0;
    logic         msg_ready_o;
    logic [7:0]   dst_cord_i = '0;
    logic [47:0]  msg_header_i = '0;
    logic         msg_has_data_i = 1'b0;
    logic [511:0] msg_data_i = '0;
    logic [63:0]  link_data_o;
    logic         link_v_o;
    logic         link_ready_and_i = 1'b1;
`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
    logic [31:0]  stall_cnt_o;
`endif

    always #5 clk = ~clk;

    bp_cac_lce_req_packetizer dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .msg_v_i          (msg_v_i),
        .msg_ready_o      (msg_ready_o),
        .dst_cord_i       (dst_cord_i),
        .msg_header_i     (msg_header_i),
        .msg_has_data_i   (msg_has_data_i),
        .msg_data_i       (msg_data_i),
        .link_data_o      (link_data_o),
        .link_v_o         (link_v_o),
        .link_ready_and_i (link_ready_and_i)
`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int          cyc = 0;
    int          v_cycles = 0;
    bit          started = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          got_cyc[$];
    int          acc_cyc[$];
    logic [31:0] m_stall = '0;
    bit          prev_stall = 0;
    logic [63:0] prev_data = '0;
    logic [575:0] mon_img;
    int          mon_n;
    int          msg_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else pass_cnt++;
    endtask

    // Packet image: cord in bits [7:0], len [11:8], header [59:12], data above, zero padded to 576.
    function automatic int flits_for(input logic hd);
        return hd ? (8 + 4 + 48 + 512 + 63) / 64 : (8 + 4 + 48 + 63) / 64;
    endfunction

    function automatic logic [575:0] build_image(input logic [7:0] cord, input logic [47:0] hdr,
                                                 input logic hd, input logic [511:0] data);
        logic [575:0] p;
        logic [3:0]   len;
        len = 4'(flits_for(hd) - 1);
        p = 576'(cord) | (576'(len) << 8) | (576'(hdr) << 12);
        if (hd) p = p | (576'(data) << 60);
        return p;
    endfunction

    always @(negedge clk) begin
        bit exp_ready;
        if (reset_i) begin
            exp_q.delete();
            m_stall = '0;
            prev_stall = 0;
            started = 1;
        end else if (started) begin
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && link_ready_and_i);
            chk("link_v", 64'(link_v_o), 64'(exp_q.size() != 0));
            chk("msg_ready", 64'(msg_ready_o), 64'(exp_ready));
            if (link_v_o) v_cycles++;
            if (link_v_o && exp_q.size() != 0) chk("flit", link_data_o, exp_q[0]);
            if (prev_stall && link_v_o) chk("hold", link_data_o, prev_data);
`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
            chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
`endif
            prev_stall = link_v_o && !link_ready_and_i;
            prev_data  = link_data_o;
            if (exp_q.size() != 0 && !link_ready_and_i && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (exp_q.size() != 0 && link_ready_and_i) begin
                void'(exp_q.pop_front());
                got_q.push_back(link_data_o);
                got_cyc.push_back(cyc);
            end
            if (msg_v_i && exp_ready) begin
                mon_img = build_image(dst_cord_i, msg_header_i, msg_has_data_i, msg_data_i);
                mon_n   = flits_for(msg_has_data_i);
                for (int i = 0; i < mon_n; i++) exp_q.push_back(mon_img[i*64 +: 64]);
                acc_cyc.push_back(cyc);
                msg_no++;
                $display("msg %0d cyc=%0d cord=%h hdr=%h has_data=%0d flits=%0d",
                         msg_no, cyc, dst_cord_i, msg_header_i, msg_has_data_i, mon_n);
            end
        end
    end

    task automatic send(input logic [7:0] cord, input logic [47:0] hdr, input logic hd,
                        input logic [511:0] data, input bit rnd);
        bit acc;
        acc = 0;
        msg_v_i = 1'b1;
        dst_cord_i = cord;
        msg_header_i = hdr;
        msg_has_data_i = hd;
        msg_data_i = data;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = msg_ready_o;
            @(posedge clk);
            #1;
            if (rnd) link_ready_and_i = ($urandom_range(0, 3) != 0);
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic wait_idle(input bit rnd);
        bit done;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(posedge clk);
            #1;
            if (rnd) link_ready_and_i = ($urandom_range(0, 3) != 0);
            done = (exp_q.size() == 0) && !link_v_o;
        end
        if (!done) chk("drain_timeout", 64'(done), 64'd1);
        link_ready_and_i = 1'b1;
    endtask

    function automatic logic [511:0] inc_bytes();
        logic [511:0] d;
        for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i);
        return d;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [575:0] reassemble(input int base, input int n);
        logic [575:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*64 +: 64] = got_q[base + i];
        return r;
    endfunction

    initial begin
        int base, abase, v0, total_flits;
        logic [511:0] blk, blk2;
        logic hd;
`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
        logic [31:0] s0;
`endif
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        chk("rst_link_v", 64'(link_v_o), 64'd0);
        chk("rst_link_data", link_data_o, 64'd0);
        chk("rst_msg_ready", 64'(msg_ready_o), 64'd1);
`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
        chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif

        // header-only packet
        base = got_q.size(); v0 = v_cycles;
        send(8'h21, 48'hABCD_0123_4567, 1'b0, rand_block(), 0);
        msg_v_i = 1'b0;
        wait_idle(0);
        chk("t1_nflits", 64'(got_q.size() - base), 64'd1);
        chk("t1_flit", got_q[base], 64'h0ABC_D012_3456_7021);
        chk("t1_v_cycles", 64'(v_cycles - v0), 64'd1);

        // data packet of incrementing bytes
        blk = inc_bytes();
        base = got_q.size();
        send(8'h21, 48'hABCD_0123_4567, 1'b1, blk, 0);
        msg_v_i = 1'b0;
        wait_idle(0);
        chk("t2_nflits", 64'(got_q.size() - base), 64'd9);
        chk("t2_flit0", got_q[base], 64'h0ABC_D012_3456_7821);
        chk("t2_len", 64'(got_q[base][11:8]), 64'd8);
        chk("t2_flit8", got_q[base + 8], 64'h03F3_E3D3_C3B3_A393);
        chk("t2_flit8_msb", 64'(got_q[base + 8][63:60]), 64'd0);
        chk("t2_reasm", 64'(reassemble(base, 9) == build_image(8'h21, 48'hABCD_0123_4567, 1'b1, blk)), 64'd1);

        // back-to-back data packets
        blk2 = rand_block();
        base = got_q.size(); abase = acc_cyc.size();
        send(8'h12, 48'h1111_2222_3333, 1'b1, blk, 0);
        send(8'h34, 48'h4444_5555_6666, 1'b1, blk2, 0);
        msg_v_i = 1'b0;
        wait_idle(0);
        chk("t3_nflits", 64'(got_q.size() - base), 64'd18);
        chk("t3_no_bubble", 64'(got_cyc[base + 17] - got_cyc[base]), 64'd17);
        chk("t3_ready_pulse", 64'(acc_cyc[abase + 1]), 64'(got_cyc[base + 8]));

        // backpressure 1,0,0,1 during a data packet
`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
        s0 = stall_cnt_o;
`endif
        base = got_q.size();
        send(8'h56, 48'h7777_8888_9999, 1'b1, blk2, 0);
        msg_v_i = 1'b0;
        link_ready_and_i = 1'b1;
        @(posedge clk); #1 link_ready_and_i = 1'b0;
        @(posedge clk); #1 link_ready_and_i = 1'b0;
        @(posedge clk); #1 link_ready_and_i = 1'b1;
        wait_idle(0);
        chk("t4_nflits", 64'(got_q.size() - base), 64'd9);
        chk("t4_reasm", 64'(reassemble(base, 9) == build_image(8'h56, 48'h7777_8888_9999, 1'b1, blk2)), 64'd1);
`ifdef BP_CAC_PACKETIZER_STALL_CNT_EN
        chk("t4_stall_cnt", 64'(stall_cnt_o - s0), 64'd2);
`endif

        // reset while flit 4 of 9 is on the link
        base = got_q.size();
        send(8'h78, 48'hAAAA_BBBB_CCCC, 1'b1, blk, 0);
        msg_v_i = 1'b0;
        for (int k = 0; k < 50 && got_q.size() < base + 3; k++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_pre_flits", 64'(got_q.size() - base), 64'd3);
        reset_i = 1'b1;
        @(posedge clk);
        #1 reset_i = 1'b0;
        chk("t5_link_v", 64'(link_v_o), 64'd0);
        chk("t5_link_data", link_data_o, 64'd0);
        chk("t5_msg_ready", 64'(msg_ready_o), 64'd1);
        base = got_q.size();
        send(8'h5A, 48'h1234_5678_9ABC, 1'b0, blk, 0);
        msg_v_i = 1'b0;
        wait_idle(0);
        chk("t5_nflits", 64'(got_q.size() - base), 64'd1);
        chk("t5_flit", got_q[base], 64'h0123_4567_89AB_C05A);

        // random traffic
        base = got_q.size();
        total_flits = 0;
        for (int m = 0; m < 1000; m++) begin
            int gap;
            gap = $urandom_range(0, 2);
            msg_v_i = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1 link_ready_and_i = ($urandom_range(0, 3) != 0);
            end
            hd = 1'($urandom_range(0, 1));
            total_flits += flits_for(hd);
            send(8'($urandom), {16'($urandom), 32'($urandom)}, hd, rand_block(), 1);
        end
        msg_v_i = 1'b0;
        wait_idle(1);
        chk("t6_total_flits", 64'(got_q.size() - base), 64'(total_flits));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
